// File: rtl/arb_pkg.sv
// Shared constants, state encoding and helpers for the eight-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ  = 8;
  localparam int IDX_W  = 3;
  localparam int HOLD_W = 8;

  localparam logic [HOLD_W-1:0] HOLD_SAT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } arb_state_e;

  // Index of the lowest set bit; zero when the vector is empty (caller qualifies with |v).
  function automatic logic [IDX_W-1:0] first_set(input logic [N_REQ-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/onehot_dec3to8.sv
// Combinational 3-to-8 one-hot decoder feeding the registered grant vector.
module onehot_dec3to8
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  always_comb begin
    onehot = '0;
    unique case (idx)
      3'd0: onehot = 8'h01;
      3'd1: onehot = 8'h02;
      3'd2: onehot = 8'h04;
      3'd3: onehot = 8'h08;
      3'd4: onehot = 8'h10;
      3'd5: onehot = 8'h20;
      3'd6: onehot = 8'h40;
      3'd7: onehot = 8'h80;
      default: onehot = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with a one-cycle turnaround gap and an optional hold limit.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             preempt
);

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
  localparam bit HOLD_UNLIMITED = (MAX_HOLD == 0);

  arb_state_e state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic              preempt_q, preempt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [N_REQ-1:0]   req_m;
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic               any_req;
  logic [IDX_W-1:0]   win_idx;
  logic [N_REQ-1:0]   win_onehot;
  logic               owner_req;

  // Rotate so the client at ptr lands in bit 0, priority-encode, then rotate the index back.
  always_comb begin
    req_m   = en ? req : '0;
    req_dbl = {req_m, req_m} >> ptr_q;
    req_rot = req_dbl[N_REQ-1:0];
    any_req = |req_m;
    win_idx = first_set(req_rot) + ptr_q;
  end

  assign owner_req = req[gnt_idx_q];

  onehot_dec3to8 u_dec (
    .idx    (win_idx),
    .onehot (win_onehot)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    hold_cnt_d  = hold_cnt_q;
    preempt_d   = 1'b0;

    unique case (state_q)
      IDLE, GAP: begin
        if (any_req) begin
          state_d     = GRANT;
          gnt_d       = win_onehot;
          gnt_idx_d   = win_idx;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = 8'd1;
        end else begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
        end
      end

      GRANT: begin
        // A voluntary release wins over a limit hit in the same cycle, so preempt stays low.
        if (!owner_req) begin
          state_d     = GAP;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_idx_q + 3'd1;
        end else if (!HOLD_UNLIMITED && (hold_cnt_q == HOLD_LIM)) begin
          state_d     = GAP;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_idx_q + 3'd1;
          preempt_d   = 1'b1;
        end else if (hold_cnt_q != HOLD_SAT) begin
          hold_cnt_d  = hold_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: three instances cover default, short and unlimited hold limits.
module tb_rr_arbiter_8;
  import arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  logic       en_a, en_b, en_c;
  logic [7:0] req_a, req_b, req_c;
  logic [7:0] gnt_a, gnt_b, gnt_c;
  logic [2:0] idx_a, idx_b, idx_c;
  logic       val_a, val_b, val_c;
  logic       pre_a, pre_b, pre_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_arbiter_8 #(.MAX_HOLD(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .req(req_a),
    .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(val_a), .preempt(pre_a)
  );

  rr_arbiter_8 #(.MAX_HOLD(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .req(req_b),
    .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(val_b), .preempt(pre_b)
  );

  rr_arbiter_8 #(.MAX_HOLD(0)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .en(en_c), .req(req_c),
    .gnt(gnt_c), .gnt_idx(idx_c), .gnt_valid(val_c), .preempt(pre_c)
  );

  typedef struct {
    logic [7:0] req;
    logic       en;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       pre;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock and land 1 ns after the rising edge, well away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string name, input logic [7:0] g, input logic [2:0] i,
                         input logic v, input logic p);
    check({name, ".gnt"}, gnt_a, g);
    check({name, ".idx"}, {5'd0, idx_a}, {5'd0, i});
    check({name, ".valid"}, {7'd0, val_a}, {7'd0, v});
    check({name, ".preempt"}, {7'd0, pre_a}, {7'd0, p});
  endtask

  initial begin
    // Basic grant/release, priority after release, and enable behaviour on instance A.
    vecs[0]  = '{8'h01, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[1]  = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[2]  = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[3]  = '{8'h20, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0};
    vecs[4]  = '{8'h64, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0};
    vecs[5]  = '{8'h44, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0};
    vecs[6]  = '{8'h44, 1'b1, 8'h40, 3'd6, 1'b1, 1'b0};
    vecs[7]  = '{8'h04, 1'b1, 8'h00, 3'd6, 1'b0, 1'b0};
    vecs[8]  = '{8'h04, 1'b1, 8'h04, 3'd2, 1'b1, 1'b0};
    vecs[9]  = '{8'h00, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0};
    vecs[10] = '{8'h10, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0};
    vecs[11] = '{8'h10, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0};
    vecs[12] = '{8'h10, 1'b1, 8'h10, 3'd4, 1'b1, 1'b0};
    vecs[13] = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    vecs[14] = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
    vecs[15] = '{8'h00, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0};
    vecs[16] = '{8'h10, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0};

    rst_n = 1'b0;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    req_a = '0;  req_b = '0;  req_c = '0;
    #2;
    check_a("reset_a", 8'h00, 3'd0, 1'b0, 1'b0);
    check("reset_b.gnt", gnt_b, 8'h00);
    check("reset_c.gnt", gnt_c, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 17; k++) begin
      req_a = vecs[k].req;
      en_a  = vecs[k].en;
      step();
      check_a($sformatf("vec%0d", k), vecs[k].gnt, vecs[k].idx, vecs[k].valid, vecs[k].pre);
    end
    req_a = '0;
    en_a  = 1'b0;

    // Hold limit 4 with everyone requesting: 0..7,0 each for 4 cycles, gap carries the preempt pulse.
    en_b  = 1'b1;
    req_b = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        check($sformatf("rot%0d_c%0d.gnt", g, c), gnt_b, 8'h01 << (g % 8));
        check($sformatf("rot%0d_c%0d.idx", g, c), {5'd0, idx_b}, 8'(g % 8));
        check($sformatf("rot%0d_c%0d.preempt", g, c), {7'd0, pre_b}, 8'h00);
      end
      step();
      check($sformatf("rot%0d_gap.gnt", g), gnt_b, 8'h00);
      check($sformatf("rot%0d_gap.preempt", g), {7'd0, pre_b}, 8'h01);
    end

    // Release on the very cycle the limit is reached: no preempt pulse.
    req_b = 8'h01;
    step();
    check("rel_lim.first", gnt_b, 8'h01);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("rel_lim.hold%0d", c), gnt_b, 8'h01);
    end
    req_b = 8'h00;
    step();
    check("rel_lim.gnt", gnt_b, 8'h00);
    check("rel_lim.preempt", {7'd0, pre_b}, 8'h00);
    en_b = 1'b0;

    // Unlimited hold: 300 continuous cycles, counter pinned at 255, no preempt.
    en_c  = 1'b1;
    req_c = 8'h08;
    for (int c = 0; c < 300; c++) begin
      step();
      check($sformatf("unlim%0d.gnt", c), gnt_c, 8'h08);
      check($sformatf("unlim%0d.preempt", c), {7'd0, pre_c}, 8'h00);
    end
    check("unlim.hold_cnt", u_dut_c.hold_cnt_q, 8'hFF);
    req_c = 8'h00;
    step();
    check("unlim.release", gnt_c, 8'h00);

    // Asynchronous reset in the middle of a grant, then first grant uses ptr=0.
    en_a  = 1'b1;
    req_a = 8'h20;
    step();
    check_a("pre_rst", 8'h20, 3'd5, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_a("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    req_a = 8'h21;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_a("post_rst", 8'h01, 3'd0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
